// File: rtl/aes_round_sched.sv
// Control sequencer for an iterative AES-128 round datapath: accepts one job,
// walks the rounds with the matching round constants, then holds the result.
module aes_round_sched #(
   parameter int unsigned NR           = 10,
   parameter int unsigned ROUND_CYCLES = 1,
   parameter int unsigned CNT_W        = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             abort,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             dp_load,
   output logic             dp_round_en,
   output logic [3:0]       dp_round,
   output logic [7:0]       dp_rcon,
   output logic             dp_final,
   output logic             busy,
   output logic [CNT_W-1:0] done_cnt
);

   localparam int unsigned CCW = (ROUND_CYCLES > 1) ? $clog2(ROUND_CYCLES) : 1;
   localparam logic [CCW-1:0] CycLast   = CCW'(ROUND_CYCLES - 1);
   localparam logic [3:0]     RoundLast = 4'(NR);

   typedef enum logic [1:0] {StIdle, StLoad, StRound, StDone} state_e;

   state_e           state_q, state_d;
   logic [CCW-1:0]   cyc_q, cyc_d;
   logic [3:0]       round_q, round_d;
   logic [7:0]       rcon_q, rcon_d;
   logic [CNT_W-1:0] done_cnt_q, done_cnt_d;
   logic             dp_load_q, dp_load_d;
   logic             round_en_q, round_en_d;
   logic             final_q, final_d;
   logic             out_valid_q, out_valid_d;
   logic             busy_q, busy_d;

   // Multiply by x in GF(2^8) modulo the AES polynomial.
   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   always_comb begin
      state_d    = state_q;
      cyc_d      = cyc_q;
      round_d    = round_q;
      rcon_d     = rcon_q;
      done_cnt_d = done_cnt_q;

      unique case (state_q)
         StIdle: begin
            if (in_valid) state_d = StLoad;
         end
         StLoad: begin
            state_d = StRound;
            round_d = 4'd1;
            rcon_d  = 8'h01;
            cyc_d   = '0;
         end
         StRound: begin
            if (cyc_q == CycLast) begin
               if (round_q == RoundLast) begin
                  state_d = StDone;
               end else begin
                  round_d = round_q + 4'd1;
                  rcon_d  = xtime(rcon_q);
                  cyc_d   = '0;
               end
            end else begin
               cyc_d = cyc_q + CCW'(1);
            end
         end
         StDone: begin
            if (out_ready) begin
               state_d    = StIdle;
               done_cnt_d = done_cnt_q + CNT_W'(1);
            end
         end
         default: state_d = StIdle;
      endcase

      // Abort beats a same-cycle delivery, so the job is not counted.
      if (abort && (state_q != StIdle)) begin
         state_d    = StIdle;
         done_cnt_d = done_cnt_q;
      end

      if (state_d == StIdle) begin
         round_d = '0;
         rcon_d  = '0;
         cyc_d   = '0;
      end

      // Outputs are decoded from the next state so they come straight off flops.
      dp_load_d   = (state_d == StLoad);
      round_en_d  = (state_d == StRound) && (cyc_d == CycLast);
      final_d     = (state_d == StRound) && (round_d == RoundLast);
      out_valid_d = (state_d == StDone);
      busy_d      = (state_d != StIdle);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         cyc_q       <= '0;
         round_q     <= '0;
         rcon_q      <= '0;
         done_cnt_q  <= '0;
         dp_load_q   <= 1'b0;
         round_en_q  <= 1'b0;
         final_q     <= 1'b0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cyc_q       <= cyc_d;
         round_q     <= round_d;
         rcon_q      <= rcon_d;
         done_cnt_q  <= done_cnt_d;
         dp_load_q   <= dp_load_d;
         round_en_q  <= round_en_d;
         final_q     <= final_d;
         out_valid_q <= out_valid_d;
         busy_q      <= busy_d;
      end
   end

   assign in_ready    = (state_q == StIdle);
   assign out_valid   = out_valid_q;
   assign dp_load     = dp_load_q;
   assign dp_round_en = round_en_q;
   assign dp_round    = round_q;
   assign dp_rcon     = rcon_q;
   assign dp_final    = final_q;
   assign busy        = busy_q;
   assign done_cnt    = done_cnt_q;

endmodule
